imem_stream_loader: RTL and testbench
=====================================

Name: imem_stream_loader

Overview:
- Boot-time writer for the processor's instruction memory; replaces file preloading with a byte-stream load path.
- Accepts a length-prefixed, checksummed byte stream, typically from a UART receiver.
- Assembles little-endian 32-bit instruction words and writes them to consecutive IMEM word addresses.
- Holds the processor in reset until a complete, checksum-valid image has been written.

Parameters:
ADDR_WIDTH, 8, IMEM word-address width; image capacity is 2**ADDR_WIDTH words.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle pulse; re-arms the loader from DONE or ERR.
rx_data  input  8  stream byte.
rx_valid  input  1  rx_data is valid this cycle.
rx_ready  output  1  loader can accept a byte; a transfer occurs when rx_valid and rx_ready are both 1.
imem_we  output  1  IMEM write strobe, one cycle per word.
imem_addr  output  ADDR_WIDTH  IMEM word address.
imem_wdata  output  32  instruction word.
cpu_rst  output  1  processor reset; 1 until a valid image is loaded.
load_done  output  1  image loaded and checksum matched (level).
load_err  output  1  length or checksum error (level).

Behaviour:
- Stream format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4*N payload bytes, each word least-significant byte first.
  - CSUM: XOR of every preceding byte, length bytes included.
- Reset values: state LEN_LO, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, load_done=0, load_err=0, running checksum 0, byte/word counters 0.
- FSM states: LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR. Transitions happen only on an accepted byte, except where noted.
  - LEN_LO -> LEN_HI.
  - LEN_HI:
    - N > 2**ADDR_WIDTH -> ERR.
    - N == 0 -> CSUM.
    - otherwise -> DATA.
  - DATA:
    - Bytes are shifted into a 32-bit assembly register; a 2-bit lane counter tracks position.
    - On acceptance of byte 3 of word k: the next cycle drives imem_we=1, imem_addr=k, imem_wdata={b3,b2,b1,b0}.
    - imem_we deasserts the following cycle unless another word completes.
    - After word N-1 completes -> CSUM.
  - CSUM:
    - Byte equals running XOR -> DONE.
    - Otherwise -> ERR.
  - DONE:
    - Registered outputs: load_done=1 and cpu_rst=0 from the cycle after the CSUM byte is accepted.
    - rx_ready=0.
  - ERR:
    - Registered outputs: load_err=1 and cpu_rst=1.
    - rx_ready=0.
  - DONE/ERR + start (no byte needed) -> LEN_LO next cycle.
    - Clears load_done, load_err, checksum and counters.
    - Asserts cpu_rst=1.
    - IMEM contents are not cleared.
- rx_ready:
  - Combinational from state: 1 in LEN_LO, LEN_HI, DATA, CSUM.
  - 0 in DONE and ERR.
  - Never depends on rx_valid.
- Gaps in the stream: rx_valid low for any number of cycles stalls the FSM with no state change. There is no timeout.
- start while loading (LEN_LO..CSUM) is ignored.
- Word counter:
  - Width ADDR_WIDTH+1, so N = 2**ADDR_WIDTH is legal.
  - imem_addr is its low ADDR_WIDTH bits; no wrap-around write can occur.
- Asynchronous rst mid-load:
  - Immediately returns every output to its reset value, including cpu_rst=1 and imem_we=0.
  - A partially assembled word is discarded and never written.
- A failed checksum leaves the already-written words in IMEM; cpu_rst stays 1, so they never execute.

Decomposition:
- Shared package:
  - State encoding constants.
  - Header-length constant (2 bytes).
  - Instruction-word width (32).
- One natural sub-module, imem_word_assembler: byte shift register plus lane counter, emits word_valid/word.
- The FSM, checksum, and address counter stay in the top level.

Test Plan:
- Two-word image: stream 02 00, then 13 00 50 00 (addi x0-style word 0x00500013), then 93 00 A0 00, then CSUM = XOR of all 10 bytes.
  -> imem_we pulses at addr 0 (0x00500013) and addr 1 (0x00A00093).
  -> load_done=1 and cpu_rst=0 one cycle after CSUM.
- Same image with CSUM XOR 0x01 -> load_err=1, cpu_rst stays 1, load_done=0, rx_ready=0.
- Zero length: stream 00 00 00 -> no imem_we; load_done=1.
- Oversize with ADDR_WIDTH=8: length 01 01 (257) -> ERR immediately after LEN_HI, no writes. Length 00 01 (256) is accepted.
- Backpressure gaps: rx_valid low 0–5 random cycles between bytes -> identical writes and timing relative to accepted bytes.
- Reset and restart:
  - Assert rst after 6 payload bytes -> outputs return to reset values at once, only word 0 written; a full re-stream then loads correctly.
  - start pulse from DONE -> load_done clears, cpu_rst=1, a second image loads correctly.

Source files
------------

// File: rtl/imem_stream_loader_pkg.sv
// Shared constants for the IMEM byte-stream loader: FSM encoding and stream framing.
package imem_stream_loader_pkg;

    localparam int WORD_W    = 32;
    localparam int HDR_BYTES = 2;

    localparam logic [2:0] ST_LEN_LO = 3'd0;
    localparam logic [2:0] ST_LEN_HI = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_CSUM   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    function automatic logic is_loading(input logic [2:0] st);
        return (st == ST_LEN_LO) || (st == ST_LEN_HI) || (st == ST_DATA) || (st == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_stream_loader_word_assembler.sv
// Collects little-endian payload bytes into 32-bit instruction words.
module imem_word_assembler
    import imem_stream_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_vld,
    input  logic [7:0]        byte_in,
    output logic              lane3,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    // Only the first three bytes are held; the fourth goes straight into word.
    logic [WORD_W-9:0] sr;
    logic [1:0]        lane;

    assign lane3 = (lane == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            lane       <= 2'd0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                sr   <= '0;
                lane <= 2'd0;
            end else if (byte_vld) begin
                lane <= lane + 2'd1;
                if (lane3) begin
                    word_valid <= 1'b1;
                    word       <= {byte_in, sr};
                end else begin
                    sr <= {byte_in, sr[WORD_W-9:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_stream_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into IMEM
// and holds the CPU in reset until a checksum-valid image has been written.
module imem_stream_loader
    import imem_stream_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_W-1:0]     imem_wdata,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  load_err
);

    localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

    logic [2:0]          state;
    logic [7:0]          len_lo;
    logic [15:0]         len;
    logic [7:0]          csum;
    logic [ADDR_WIDTH:0] wcnt;
    logic                accept;
    logic                rearm;
    logic                lane3;
    logic                word_done;
    logic                last_word;
    logic [16:0]         len_full;

    assign rx_ready  = is_loading(state);
    assign accept    = rx_valid && rx_ready;
    assign rearm     = start && ((state == ST_DONE) || (state == ST_ERR));
    assign word_done = accept && (state == ST_DATA) && lane3;
    assign last_word = (17'(wcnt) + 17'd1) == {1'b0, len};
    assign len_full  = {1'b0, rx_data, len_lo};

    imem_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (rearm),
        .byte_vld   (accept && (state == ST_DATA)),
        .byte_in    (rx_data),
        .lane3      (lane3),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_LEN_LO;
            len_lo    <= '0;
            len       <= '0;
            csum      <= '0;
            wcnt      <= '0;
            imem_addr <= '0;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else if (rearm) begin
            state     <= ST_LEN_LO;
            len_lo    <= '0;
            len       <= '0;
            csum      <= '0;
            wcnt      <= '0;
            imem_addr <= '0;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else if (accept) begin
            if (state != ST_CSUM)
                csum <= csum ^ rx_data;
            case (state)
                ST_LEN_LO: begin
                    len_lo <= rx_data;
                    state  <= ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    len <= len_full[15:0];
                    if (len_full > CAP) begin
                        state    <= ST_ERR;
                        load_err <= 1'b1;
                    end else if (len_full == 17'd0) begin
                        state <= ST_CSUM;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Address is latched with the word so it lines up with imem_we.
                    if (word_done) begin
                        imem_addr <= wcnt[ADDR_WIDTH-1:0];
                        wcnt      <= wcnt + 1'b1;
                        if (last_word)
                            state <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (rx_data == csum) begin
                        state     <= ST_DONE;
                        load_done <= 1'b1;
                        cpu_rst   <= 1'b0;
                    end else begin
                        state    <= ST_ERR;
                        load_err <= 1'b1;
                    end
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: image loads, checksum/length errors, gaps, reset and restart.
module tb_imem_stream_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          load_done;
    logic          load_err;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] wq_a[$];
    logic [31:0]   wq_d[$];
    logic [31:0]   img_words[$];

    imem_stream_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wq_a.push_back(imem_addr);
            wq_d.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one byte at posedge+1 phase; returns at posedge+1 after it is accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        chk("rx_ready_before_byte", rx_ready, 1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_done_clr", load_done, 0);
        chk("start_err_clr", load_err, 0);
        chk("start_cpu_rst", cpu_rst, 1);
        chk("start_rx_ready", rx_ready, 1);
    endtask

    task automatic send_image(input logic [15:0] n, input logic [7:0] cs, input int max_gap, input bit ok);
        logic [7:0] bq[$];
        int base;
        int p;
        bq.push_back(n[7:0]);
        bq.push_back(n[15:8]);
        for (int k = 0; k < int'(n); k++)
            for (int b = 0; b < 4; b++)
                bq.push_back(img_words[k][8*b +: 8]);
        base = wq_a.size();
        for (int i = 0; i < bq.size(); i++) begin
            send_byte(bq[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
            if (i >= 2) begin
                p = i - 2;
                if (p % 4 == 3) begin
                    chk("we_on_word", imem_we, 1);
                    chk("addr_on_word", imem_addr, 32'(p / 4));
                    chk("wdata_on_word", imem_wdata, img_words[p / 4]);
                end else begin
                    chk("we_idle", imem_we, 0);
                end
            end
        end
        send_byte(cs, (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
        chk("done_after_csum", load_done, ok ? 1 : 0);
        chk("err_after_csum", load_err, ok ? 0 : 1);
        chk("cpu_rst_after_csum", cpu_rst, ok ? 0 : 1);
        chk("rx_ready_after_csum", rx_ready, 0);
        chk("write_count", wq_a.size() - base, 32'(n));
        for (int k = 0; k < int'(n) && base + k < wq_a.size(); k++) begin
            chk("log_addr", wq_a[base + k], 32'(k));
            chk("log_data", wq_d[base + k], img_words[k]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cs256;
        int base;
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #3;
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Two-word image, checksum 02^00^13^00^50^00^93^00^A0^00 = 72
        img_words = '{32'h00500013, 32'h00A00093};
        send_image(16'd2, 8'h72, 0, 1'b1);

        // Corrupted checksum
        pulse_start();
        send_image(16'd2, 8'h73, 0, 1'b0);

        // Zero-length image
        pulse_start();
        img_words = '{};
        send_image(16'd0, 8'h00, 0, 1'b1);

        // Oversize length 257
        pulse_start();
        base = wq_a.size();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk("oversize_err", load_err, 1);
        chk("oversize_rx_ready", rx_ready, 0);
        chk("oversize_cpu_rst", cpu_rst, 1);
        chk("oversize_done", load_done, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("oversize_no_writes", wq_a.size() - base, 0);

        // Full-capacity image of 256 words
        pulse_start();
        img_words = '{};
        cs256 = 8'h00 ^ 8'h01;
        for (int k = 0; k < 256; k++) begin
            img_words.push_back({8'hC3, 8'(k), ~8'(k), 8'(k) ^ 8'h5A});
            cs256 = cs256 ^ 8'hC3 ^ 8'(k) ^ ~8'(k) ^ (8'(k) ^ 8'h5A);
        end
        send_image(16'd256, cs256, 0, 1'b1);

        // Random gaps between bytes
        pulse_start();
        img_words = '{32'h00500013, 32'h00A00093};
        send_image(16'd2, 8'h72, 5, 1'b1);

        // Async reset after 6 payload bytes
        pulse_start();
        base = wq_a.size();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
        send_byte(8'h93, 0); send_byte(8'h00, 0);
        rst = 1'b1;
        #1;
        chk("midrst_we", imem_we, 0);
        chk("midrst_addr", imem_addr, 0);
        chk("midrst_wdata", imem_wdata, 0);
        chk("midrst_cpu_rst", cpu_rst, 1);
        chk("midrst_rx_ready", rx_ready, 1);
        chk("midrst_done", load_done, 0);
        chk("midrst_err", load_err, 0);
        chk("midrst_one_write", wq_a.size() - base, 1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        send_image(16'd2, 8'h72, 0, 1'b1);

        // Restart from DONE with a second image: 01^00^EF^BE^AD^DE = 23
        pulse_start();
        img_words = '{32'hDEADBEEF};
        send_image(16'd1, 8'h23, 2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
